scan_display_ctrl: RTL and testbench
====================================

SCAN_DISPLAY_CTRL -- requirements
Module: scan_display_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 3: number of multiplexed digits (1..8).
REQ-002 SHALL have parameter PRESCALE, default 1: clocks per scan tick (1..65535).
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load  input  1  one-cycle strobe; capture BCD, dp_in and lzs_en.
REQ-006 SHALL have port BCD  input  4*DIGITS  digit k on BCD[4k+3:4k]; digit 0 is least significant.
REQ-007 SHALL have port dp_in  input  DIGITS  decimal point of digit k on bit k.
REQ-008 SHALL have port lzs_en  input  1  leading-zero suppression enable.
REQ-009 SHALL have port bright  input  4  duty level 0..15, sampled live.
REQ-010 SHALL have port S  output  DIGITS  one-hot digit select, active high.
REQ-011 SHALL have port LED  output  7  segments {g,f,e,d,c,b,a}, 1 = lit.
REQ-012 SHALL have port DP  output  1  decimal point of the selected digit, 1 = lit.
REQ-013 SHALL have port busy  output  1  high while a captured update is pending.
REQ-014 SHALL have port frame  output  1  one-clock pulse at each frame boundary.

Function
REQ-015 SHALL assert a tick when the prescaler counter (0..PRESCALE-1) equals PRESCALE-1; the counter then wraps to 0.
REQ-016 SHALL count 16 sub-ticks per slot and 2*DIGITS slots per frame; the slot counter advances when the sub-tick counter wraps 15->0.
REQ-017 SHALL treat even slots as blank (S=0, LED=0, DP=0) and odd slot 2k+1 as active for digit k.
REQ-018 SHALL, in an active slot, drive S=1<<k only while sub-tick < bright; otherwise S, LED and DP SHALL be 0. bright=0 never lights; bright=15 lights 15 of 16 sub-ticks.
REQ-019 SHALL decode digit values 0..9 as 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex); values 10..15 SHALL yield LED=00.
REQ-020 SHALL, when shadow lzs=1, blank LED for digit k>0 if digit k and all more significant digits are 0. Digit 0 is never suppressed, and DP is never suppressed.
REQ-021 SHALL register S, LED and DP, so outputs lag the counter state by exactly 1 clock.
REQ-022 SHALL, on load, capture the inputs into a pending register at that edge and set busy=1 from the next cycle.
REQ-023 SHALL overwrite pending contents on a load while busy=1 (last write wins).
REQ-024 SHALL define the frame boundary as the tick on which slot 2*DIGITS-1 sub-tick 15 wraps to slot 0. At that edge: frame=1 for one cycle, pending copies to shadow, and busy clears.
REQ-025 SHALL, if load coincides with a frame boundary, write the load data directly to shadow and leave busy=0.
REQ-026 SHALL display only shadow contents; the display never changes mid-frame.

Reset
REQ-027 SHALL, while reset=1 at an edge, clear the prescaler, sub-tick and slot counters, pending, shadow (including lzs and dp), S, LED, DP, busy and frame to 0.
REQ-028 SHALL let reset override load and the frame transfer; a mid-frame reset discards the pending update.
REQ-029 SHALL restart at slot 0, sub-tick 0 on the first edge after reset deasserts.

Verification (DIGITS=3, PRESCALE=1: slot = 16 clocks, frame = 96 clocks)
REQ-030 SHALL cover: reset, then load BCD=0x123, bright=15 -> busy=1 until the first frame pulse. In the following frame, slot 1 gives S=001 LED=4F; slot 3 gives S=010 LED=5B; slot 5 gives S=100 LED=06; even slots give S=0.
REQ-031 SHALL cover: load BCD=0x007, lzs_en=1, dp_in=3'b100 -> digit 0 LED=07; digit 1 LED=00; digit 2 LED=00 with DP=1.
REQ-032 SHALL cover: bright=4 -> each active slot shows S nonzero for exactly 4 clocks, then 12 clocks of 0.
REQ-033 SHALL cover: load 0x111 then 0x222 within one frame -> 0x222 is displayed next frame and 0x111 never appears.
REQ-034 SHALL cover: load asserted on the frame-pulse cycle -> the new value shows from slot 1 of that frame and busy stays 0.
REQ-035 SHALL cover: reset asserted during slot 3 with busy=1 -> all outputs are 0 next cycle; after release, BCD 0x000 is displayed as 3F on all digits.

Source files
------------

// File: rtl/scan_display_ctrl.sv
// scan_display_ctrl
//   Time-multiplexed 7-segment display controller with double-buffered
//   digit data, leading-zero suppression and PWM brightness.
//
//   Each frame has 2*DIGITS slots of 16 sub-ticks each. Even slots are
//   blank guard slots. Odd slot 2k+1 drives digit k. Within an active
//   slot the digit lights only while sub-tick < bright.
//
//   Ports
//     clock   : sole clock, rising edge
//     reset   : synchronous, active-high
//     load    : one-cycle strobe capturing BCD / dp_in / lzs_en
//     BCD     : 4 bits per digit, digit 0 least significant
//     dp_in   : decimal point per digit
//     lzs_en  : leading-zero suppression enable
//     bright  : duty level 0..15, used live
//     S       : one-hot digit select, active high (registered)
//     LED     : segments {g,f,e,d,c,b,a}, 1 = lit (registered)
//     DP      : decimal point of the selected digit (registered)
//     busy    : a captured update is waiting for the next frame boundary
//     frame   : one-clock pulse after each frame boundary
//
//   Handshake: load is a fire-and-forget strobe with no ready. It is always
//   accepted; busy is status only, and a load while busy replaces the
//   pending data (last write wins). Data reaches the display only at a
//   frame boundary, so a frame is never drawn from mixed data.
module scan_display_ctrl #(
    parameter int DIGITS   = 3,
    parameter int PRESCALE = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   BCD,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lzs_en,
    input  logic [3:0]            bright,
    output logic [DIGITS-1:0]     S,
    output logic [6:0]            LED,
    output logic                  DP,
    output logic                  busy,
    output logic                  frame
);

    localparam int SLOTS  = 2 * DIGITS;
    localparam int SLOT_W = $clog2(SLOTS);

    logic [15:0]         presc;
    logic [3:0]          sub;
    logic [SLOT_W-1:0]   slot;
    logic                tick;
    logic                last_slot;
    logic                frame_edge;

    logic [4*DIGITS-1:0] pend_bcd;
    logic [DIGITS-1:0]   pend_dp;
    logic                pend_lzs;
    logic [4*DIGITS-1:0] sh_bcd;
    logic [DIGITS-1:0]   sh_dp;
    logic                sh_lzs;

    logic [DIGITS-1:0]   supp;
    logic                all_zero;
    logic                lit;
    logic [SLOT_W-1:0]   k_sel;
    logic [DIGITS-1:0]   s_nxt;
    logic [6:0]          led_nxt;
    logic                dp_nxt;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign tick       = (presc == 16'(PRESCALE - 1));
    assign last_slot  = (slot == SLOT_W'(SLOTS - 1));
    assign frame_edge = tick && (sub == 4'd15) && last_slot;

    // Scan counters: prescaler -> sub-tick -> slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc <= '0;
            sub   <= '0;
            slot  <= '0;
        end else begin
            presc <= tick ? 16'd0 : presc + 16'd1;
            if (tick) begin
                sub <= sub + 4'd1;
                if (sub == 4'd15)
                    slot <= last_slot ? '0 : slot + SLOT_W'(1);
            end
        end
    end

    // Double buffer. A load landing exactly on the boundary edge bypasses
    // pending so it is shown in the frame that starts at that edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_bcd <= '0;
            pend_dp  <= '0;
            pend_lzs <= 1'b0;
            sh_bcd   <= '0;
            sh_dp    <= '0;
            sh_lzs   <= 1'b0;
            busy     <= 1'b0;
            frame    <= 1'b0;
        end else begin
            frame <= frame_edge;
            if (frame_edge) begin
                busy <= 1'b0;
                if (load) begin
                    sh_bcd   <= BCD;
                    sh_dp    <= dp_in;
                    sh_lzs   <= lzs_en;
                    pend_bcd <= BCD;
                    pend_dp  <= dp_in;
                    pend_lzs <= lzs_en;
                end else if (busy) begin
                    sh_bcd <= pend_bcd;
                    sh_dp  <= pend_dp;
                    sh_lzs <= pend_lzs;
                end
            end else if (load) begin
                pend_bcd <= BCD;
                pend_dp  <= dp_in;
                pend_lzs <= lzs_en;
                busy     <= 1'b1;
            end
        end
    end

    // A digit is suppressed when it and every more significant digit are
    // zero; walking from the top keeps a running "all zero so far" flag.
    always_comb begin
        all_zero = 1'b1;
        supp     = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero && (sh_bcd[4*k +: 4] == 4'd0);
            supp[k]  = sh_lzs && all_zero && (k != 0);
        end
    end

    assign lit   = slot[0] && (sub < bright);
    assign k_sel = slot >> 1;

    always_comb begin
        s_nxt   = '0;
        led_nxt = '0;
        dp_nxt  = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (lit && (k_sel == SLOT_W'(k))) begin
                s_nxt[k] = 1'b1;
                led_nxt  = supp[k] ? 7'h00 : seg7(sh_bcd[4*k +: 4]);
                dp_nxt   = sh_dp[k];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            S   <= '0;
            LED <= '0;
            DP  <= 1'b0;
        end else begin
            S   <= s_nxt;
            LED <= led_nxt;
            DP  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// tb_scan_display_ctrl
//   Directed bench for scan_display_ctrl with DIGITS=3, PRESCALE=1
//   (slot = 16 clocks, frame = 96 clocks). Inputs change on the falling
//   edge, outputs are sampled on the falling edge. After the falling edge
//   that sees frame=1, the n-th following falling edge shows the outputs
//   for frame index n-1 (slot = idx/16, sub-tick = idx%16).
module tb_scan_display_ctrl;

    localparam int DIGITS   = 3;
    localparam int PRESCALE = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic [11:0] bcd;
    logic [2:0]  dp_in;
    logic        lzs_en;
    logic [3:0]  bright;
    logic [2:0]  s;
    logic [6:0]  led;
    logic        dp;
    logic        busy;
    logic        frame;

    int checks = 0;
    int errors = 0;

    logic [2:0] s_cap    [96];
    logic [6:0] led_cap  [96];
    logic       dp_cap   [96];
    logic       busy_cap [96];
    logic       frame_cap[96];

    scan_display_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .BCD    (bcd),
        .dp_in  (dp_in),
        .lzs_en (lzs_en),
        .bright (bright),
        .S      (s),
        .LED    (led),
        .DP     (dp),
        .busy   (busy),
        .frame  (frame)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; load is seen by exactly one rising edge.
    task automatic do_load(input logic [11:0] v, input logic [2:0] d, input logic z);
        bcd    = v;
        dp_in  = d;
        lzs_en = z;
        load   = 1'b1;
        @(negedge clock);
        load   = 1'b0;
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (frame !== 1'b1 && n < 300);
        checks++;
        if (frame !== 1'b1) begin
            errors++;
            $display("FAIL wait_frame: frame=%b after %0d cycles, required 1", frame, n);
        end
    endtask

    task automatic grab_frame();
        for (int j = 0; j < 96; j++) begin
            @(negedge clock);
            s_cap[j]     = s;
            led_cap[j]   = led;
            dp_cap[j]    = dp;
            busy_cap[j]  = busy;
            frame_cap[j] = frame;
        end
    endtask

    function automatic logic [2:0] exp_s(input int idx, input int br);
        int sl;
        int sb;
        sl = idx / 16;
        sb = idx % 16;
        if ((sl % 2 == 1) && (sb < br))
            return 3'(1 << (sl / 2));
        return 3'b000;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n;
        reset = 1'b1; load = 1'b0; bcd = '0; dp_in = '0; lzs_en = 1'b0; bright = 4'd15;
        repeat (3) @(negedge clock);
        checks++; if (s !== 3'b000)    begin errors++; $display("FAIL reset_S: got %b want 000", s); end
        checks++; if (led !== 7'h00)   begin errors++; $display("FAIL reset_LED: got %h want 00", led); end
        checks++; if (dp !== 1'b0)     begin errors++; $display("FAIL reset_DP: got %b want 0", dp); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (frame !== 1'b0)  begin errors++; $display("FAIL reset_frame: got %b want 0", frame); end
        reset = 1'b0;
        wait_frame(n);
        checks++; if (n != 96) begin errors++; $display("FAIL reset_first_frame: got %0d cycles want 96", n); end
    endtask

    task automatic test_basic();
        int n;
        int bad;
        do_load(12'h123, 3'b000, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_set: got %b want 1", busy); end
        repeat (90) @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_hold: got %b want 1", busy); end
        wait_frame(n);
        checks++; if (n != 5)        begin errors++; $display("FAIL basic_frame_time: got %0d want 5", n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_clear: got %b want 0", busy); end
        grab_frame();
        checks++; if (s_cap[16] !== 3'b001 || led_cap[16] !== 7'h4F) begin errors++; $display("FAIL basic_slot1: got S=%b LED=%h want 001/4F", s_cap[16], led_cap[16]); end
        checks++; if (s_cap[48] !== 3'b010 || led_cap[48] !== 7'h5B) begin errors++; $display("FAIL basic_slot3: got S=%b LED=%h want 010/5B", s_cap[48], led_cap[48]); end
        checks++; if (s_cap[80] !== 3'b100 || led_cap[80] !== 7'h06) begin errors++; $display("FAIL basic_slot5: got S=%b LED=%h want 100/06", s_cap[80], led_cap[80]); end
        checks++; if (s_cap[31] !== 3'b000 || led_cap[31] !== 7'h00) begin errors++; $display("FAIL basic_sub15_dark: got S=%b LED=%h want 000/00", s_cap[31], led_cap[31]); end
        checks++; if (s_cap[0] !== 3'b000 || s_cap[40] !== 3'b000 || s_cap[64] !== 3'b000) begin errors++; $display("FAIL basic_even_blank: got %b %b %b want 000", s_cap[0], s_cap[40], s_cap[64]); end
        bad = 0;
        for (int j = 0; j < 96; j++) if (s_cap[j] !== exp_s(j, 15)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL basic_scan_pattern: got %0d wrong S samples want 0", bad); end
        bad = 0;
        for (int j = 0; j < 95; j++) if (frame_cap[j] !== 1'b0) bad++;
        checks++; if (bad != 0 || frame_cap[95] !== 1'b1) begin errors++; $display("FAIL basic_frame_period: got %0d extra pulses end=%b want 0/1", bad, frame_cap[95]); end
    endtask

    task automatic test_lzs();
        int n;
        do_load(12'h007, 3'b100, 1'b1);
        wait_frame(n);
        grab_frame();
        checks++; if (s_cap[16] !== 3'b001 || led_cap[16] !== 7'h07 || dp_cap[16] !== 1'b0) begin errors++; $display("FAIL lzs_digit0: got S=%b LED=%h DP=%b want 001/07/0", s_cap[16], led_cap[16], dp_cap[16]); end
        checks++; if (s_cap[48] !== 3'b010 || led_cap[48] !== 7'h00 || dp_cap[48] !== 1'b0) begin errors++; $display("FAIL lzs_digit1: got S=%b LED=%h DP=%b want 010/00/0", s_cap[48], led_cap[48], dp_cap[48]); end
        checks++; if (s_cap[80] !== 3'b100 || led_cap[80] !== 7'h00 || dp_cap[80] !== 1'b1) begin errors++; $display("FAIL lzs_digit2: got S=%b LED=%h DP=%b want 100/00/1", s_cap[80], led_cap[80], dp_cap[80]); end
        checks++; if (dp_cap[94] !== 1'b1 || dp_cap[95] !== 1'b0) begin errors++; $display("FAIL lzs_dp_pwm: got %b %b want 1 0", dp_cap[94], dp_cap[95]); end
    endtask

    task automatic test_bright();
        int cnt;
        int bad;
        bright = 4'd4;
        grab_frame();
        for (int sl = 1; sl < 6; sl += 2) begin
            cnt = 0;
            for (int t = 0; t < 16; t++) if (s_cap[sl*16 + t] !== 3'b000) cnt++;
            checks++;
            if (cnt != 4 || s_cap[sl*16 + 3] === 3'b000 || s_cap[sl*16 + 4] !== 3'b000) begin
                errors++;
                $display("FAIL bright4_slot%0d: got %0d lit clocks want 4 (first 4 sub-ticks)", sl, cnt);
            end
        end
        bright = 4'd0;
        grab_frame();
        bad = 0;
        for (int j = 0; j < 96; j++) if (s_cap[j] !== 3'b000 || led_cap[j] !== 7'h00) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL bright0_dark: got %0d lit samples want 0", bad); end
        bright = 4'd15;
    endtask

    task automatic test_back_to_back();
        int n;
        int bad;
        do_load(12'h111, 3'b000, 1'b0);
        repeat (10) @(negedge clock);
        do_load(12'h222, 3'b000, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
        wait_frame(n);
        grab_frame();
        checks++; if (led_cap[16] !== 7'h5B || led_cap[48] !== 7'h5B || led_cap[80] !== 7'h5B) begin errors++; $display("FAIL b2b_last_wins: got %h %h %h want 5B", led_cap[16], led_cap[48], led_cap[80]); end
        bad = 0;
        for (int j = 0; j < 96; j++) if (led_cap[j] === 7'h06) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_no_first: got %0d samples of 06 want 0", bad); end
    endtask

    task automatic test_boundary_load();
        int bad;
        repeat (95) @(negedge clock);
        bcd = 12'h456; dp_in = 3'b000; lzs_en = 1'b0; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        checks++; if (frame !== 1'b1) begin errors++; $display("FAIL bnd_frame: got %b want 1", frame); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL bnd_busy: got %b want 0", busy); end
        grab_frame();
        checks++; if (led_cap[16] !== 7'h7D || led_cap[48] !== 7'h6D || led_cap[80] !== 7'h66) begin errors++; $display("FAIL bnd_direct: got %h %h %h want 7D 6D 66", led_cap[16], led_cap[48], led_cap[80]); end
        bad = 0;
        for (int j = 0; j < 96; j++) if (busy_cap[j] !== 1'b0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL bnd_busy_stays_0: got %0d busy samples want 0", bad); end
    endtask

    task automatic test_mid_reset();
        int n;
        int bad;
        do_load(12'h999, 3'b000, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mrst_busy: got %b want 1", busy); end
        repeat (50) @(negedge clock);
        checks++; if (s !== 3'b010 || led !== 7'h6D) begin errors++; $display("FAIL mrst_pre: got S=%b LED=%h want 010/6D", s, led); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (s !== 3'b000 || led !== 7'h00 || dp !== 1'b0 || busy !== 1'b0 || frame !== 1'b0) begin errors++; $display("FAIL mrst_clear: got S=%b LED=%h DP=%b busy=%b frame=%b want all 0", s, led, dp, busy, frame); end
        reset = 1'b0;
        wait_frame(n);
        checks++; if (n != 96) begin errors++; $display("FAIL mrst_restart: got %0d cycles want 96", n); end
        grab_frame();
        checks++; if (led_cap[16] !== 7'h3F || led_cap[48] !== 7'h3F || led_cap[80] !== 7'h3F) begin errors++; $display("FAIL mrst_zeros: got %h %h %h want 3F", led_cap[16], led_cap[48], led_cap[80]); end
        bad = 0;
        for (int j = 0; j < 96; j++) if (led_cap[j] === 7'h6F) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL mrst_discard: got %0d samples of 6F want 0", bad); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_lzs();
        test_bright();
        test_back_to_back();
        test_boundary_load();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
